// File: rtl/ntt_pkg.sv
// Shared types and modular arithmetic helpers for the 4-point NTT.
// Helpers work on 64-bit operands so any coefficient width up to 64 bits is covered.
package ntt_pkg;

  localparam int unsigned     NTT_WIDTH = 32;
  localparam longint unsigned NTT_Q     = 5;
  localparam int unsigned     MAX_W     = 64;

  typedef logic [NTT_WIDTH-1:0] coef_t;
  typedef logic [MAX_W-1:0]     wide_t;

  function automatic wide_t mod_add(input wide_t a, input wide_t b, input wide_t q);
    logic [MAX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[MAX_W-1:0];
  endfunction

  // a + q - b may wrap in 64 bits, but the true result is below q so the wrap cancels.
  function automatic wide_t mod_sub(input wide_t a, input wide_t b, input wide_t q);
    wide_t r;
    if (a >= b) r = a - b;
    else        r = a + q - b;
    return r;
  endfunction

  function automatic wide_t mod_mul(input wide_t a, input wide_t b, input wide_t q);
    logic [2*MAX_W-1:0] p;
    p = {{MAX_W{1'b0}}, a} * {{MAX_W{1'b0}}, b};
    p = p % {{MAX_W{1'b0}}, q};
    return p[MAX_W-1:0];
  endfunction

  function automatic wide_t mod_red(input wide_t a, input wide_t q);
    return a % q;
  endfunction

endpackage

// File: rtl/ntt_butterfly.sv
// Combinational radix-2 DIT butterfly: hi = a + w*b, lo = a - w*b, all mod Q.
module ntt_butterfly
  import ntt_pkg::*;
#(
  parameter int unsigned     WIDTH = NTT_WIDTH,
  parameter longint unsigned Q     = NTT_Q
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  wide_t t;

  assign t  = mod_mul(wide_t'(w), wide_t'(b), Q);
  assign hi = WIDTH'(mod_add(wide_t'(a), t, Q));
  assign lo = WIDTH'(mod_sub(wide_t'(a), t, Q));

endmodule

// File: rtl/ntt_4pt.sv
// Two-stage pipelined 4-point NTT, natural order in and out, latency 2, one transform per cycle.
// Optional macro NTT_INPUT_REDUCE_EN reduces all inputs mod Q before stage 1.
module ntt_4pt
  import ntt_pkg::*;
#(
  parameter int unsigned     WIDTH = NTT_WIDTH,
  parameter longint unsigned Q     = NTT_Q
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  input  logic [WIDTH-1:0] w0,
  input  logic [WIDTH-1:0] w1,
  output logic             out_valid,
  output logic [WIDTH-1:0] b0,
  output logic [WIDTH-1:0] b1,
  output logic [WIDTH-1:0] b2,
  output logic [WIDTH-1:0] b3
);

  logic [WIDTH-1:0] x0r, x1r, x2r, x3r, w0r, w1r;

`ifdef NTT_INPUT_REDUCE_EN
  assign x0r = WIDTH'(mod_red(wide_t'(x0), Q));
  assign x1r = WIDTH'(mod_red(wide_t'(x1), Q));
  assign x2r = WIDTH'(mod_red(wide_t'(x2), Q));
  assign x3r = WIDTH'(mod_red(wide_t'(x3), Q));
  assign w0r = WIDTH'(mod_red(wide_t'(w0), Q));
  assign w1r = WIDTH'(mod_red(wide_t'(w1), Q));
`else
  assign x0r = x0;
  assign x1r = x1;
  assign x2r = x2;
  assign x3r = x3;
  assign w0r = w0;
  assign w1r = w1;
`endif

  logic [WIDTH-1:0] a0_d, a1_d, a2_d, a3_d;
  logic [WIDTH-1:0] a0_q, a1_q, a2_q, a3_q, w0_q, w1_q;
  logic             v1_q;
  logic [WIDTH-1:0] b0_d, b1_d, b2_d, b3_d;
  logic [WIDTH-1:0] b0_q, b1_q, b2_q, b3_q;
  logic             vout_q;

  // Stage 1 pairs even/odd-index inputs; only w0 is needed at this level.
  ntt_butterfly #(.WIDTH(WIDTH), .Q(Q)) u_bf_s1_even (
    .a(x0r), .b(x2r), .w(w0r), .hi(a0_d), .lo(a1_d)
  );
  ntt_butterfly #(.WIDTH(WIDTH), .Q(Q)) u_bf_s1_odd (
    .a(x1r), .b(x3r), .w(w0r), .hi(a2_d), .lo(a3_d)
  );

  ntt_butterfly #(.WIDTH(WIDTH), .Q(Q)) u_bf_s2_lo (
    .a(a0_q), .b(a2_q), .w(w0_q), .hi(b0_d), .lo(b2_d)
  );
  ntt_butterfly #(.WIDTH(WIDTH), .Q(Q)) u_bf_s2_hi (
    .a(a1_q), .b(a3_q), .w(w1_q), .hi(b1_d), .lo(b3_d)
  );

  // Data registers load only on their stage's valid, so results hold between transforms.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      vout_q <= 1'b0;
      a0_q   <= '0;
      a1_q   <= '0;
      a2_q   <= '0;
      a3_q   <= '0;
      w0_q   <= '0;
      w1_q   <= '0;
      b0_q   <= '0;
      b1_q   <= '0;
      b2_q   <= '0;
      b3_q   <= '0;
    end else begin
      v1_q   <= in_valid;
      vout_q <= v1_q;
      if (in_valid) begin
        a0_q <= a0_d;
        a1_q <= a1_d;
        a2_q <= a2_d;
        a3_q <= a3_d;
        w0_q <= w0r;
        w1_q <= w1r;
      end
      if (v1_q) begin
        b0_q <= b0_d;
        b1_q <= b1_d;
        b2_q <= b2_d;
        b3_q <= b3_d;
      end
    end
  end

  assign out_valid = vout_q;
  assign b0        = b0_q;
  assign b1        = b1_q;
  assign b2        = b2_q;
  assign b3        = b3_q;

endmodule

// File: tb/tb_ntt_4pt.sv
// Bench for ntt_4pt (Q=5): table vectors, back-to-back, reset-in-flight, hold, random vs direct-sum model.
// Adds the out-of-range vector when NTT_INPUT_REDUCE_EN is defined.
module tb_ntt_4pt;
  import ntt_pkg::*;

  localparam longint unsigned TQ = 5;

  typedef struct packed {
    logic [3:0][31:0] x;
    logic [31:0]      w0;
    logic [31:0]      w1;
    logic [3:0][31:0] b;
  } vec_t;

  typedef struct packed {
    logic [3:0][31:0] b;
    logic [31:0]      due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] x0, x1, x2, x3, w0, w1;
  logic        out_valid;
  logic [31:0] b0, b1, b2, b3;

  int          checks;
  int          failures;
  logic [31:0] cyc;
  exp_t        sbQ[$];
  logic [3:0][31:0] lastB;

  ntt_4pt #(.WIDTH(32), .Q(TQ)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .w0(w0), .w1(w1),
    .out_valid(out_valid), .b0(b0), .b1(b1), .b2(b2), .b3(b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = '0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Direct DFT sum b_k = sum x_n * w^(n*k) mod Q, independent of the butterfly structure.
  function automatic logic [3:0][31:0] nttRef(input logic [3:0][31:0] x, input logic [31:0] w);
    logic [3:0][31:0] r;
    longint unsigned acc, p;
    for (int k = 0; k < 4; k++) begin
      acc = 0;
      for (int n = 0; n < 4; n++) begin
        p = 1;
        for (int e = 0; e < n * k; e++) p = (p * longint'(w)) % TQ;
        acc = (acc + longint'(x[n]) * p) % TQ;
      end
      r[k] = acc[31:0];
    end
    return r;
  endfunction

  function automatic vec_t mkVec(input logic [31:0] i0, i1, i2, i3, iw0, iw1, e0, e1, e2, e3);
    vec_t v;
    v.x[0] = i0; v.x[1] = i1; v.x[2] = i2; v.x[3] = i3;
    v.w0 = iw0;  v.w1 = iw1;
    v.b[0] = e0; v.b[1] = e1; v.b[2] = e2; v.b[3] = e3;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v, input bit track);
    exp_t e;
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    x0 = v.x[0]; x1 = v.x[1]; x2 = v.x[2]; x3 = v.x[3];
    w0 = v.w0;   w1 = v.w1;
    if (track) begin
      e.b   = v.b;
      e.due = cyc + 2;
      sbQ.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      in_valid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int budget;
    budget = 0;
    while (sbQ.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (sbQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain_timeout actual=%0d pending expected=0 pending", sbQ.size());
      sbQ.delete();
    end
  endtask

  // Scoreboard consumer: every out_valid must match the oldest pending transform, on time.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("latency_cycle", 64'(cyc), 64'(e.due));
        checkOutput("b0", 64'(b0), 64'(e.b[0]));
        checkOutput("b1", 64'(b1), 64'(e.b[1]));
        checkOutput("b2", 64'(b2), 64'(e.b[2]));
        checkOutput("b3", 64'(b3), 64'(e.b[3]));
        lastB = e.b;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t table_v[$];
    vec_t v;
    logic [3:0][31:0] rx;
    logic [31:0]      rw;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    x0 = '0; x1 = '0; x2 = '0; x3 = '0; w0 = '0; w1 = '0;

    table_v.push_back(mkVec(1, 2, 3, 4, 1, 3,  0, 2, 3, 4));
    table_v.push_back(mkVec(2, 3, 3, 0, 1, 3,  3, 3, 2, 0));
    table_v.push_back(mkVec(0, 2, 3, 4, 1, 2,  4, 3, 2, 1));
    table_v.push_back(mkVec(3, 3, 2, 0, 1, 2,  3, 2, 2, 0));
    table_v.push_back(mkVec(4, 4, 4, 4, 1, 2,  1, 0, 0, 0));
    table_v.push_back(mkVec(0, 0, 0, 0, 1, 2,  0, 0, 0, 0));
`ifdef NTT_INPUT_REDUCE_EN
    table_v.push_back(mkVec(6, 7, 8, 9, 6, 8,  0, 2, 3, 4));
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_b0", 64'(b0), 64'd0);
    checkOutput("reset_b1", 64'(b1), 64'd0);
    checkOutput("reset_b2", 64'(b2), 64'd0);
    checkOutput("reset_b3", 64'(b3), 64'd0);
    rst_n = 1'b1;

    // Single pulse, then confirm outputs hold with out_valid low.
    applyStimulus(table_v[0], 1'b1);
    idle(1);
    waitDrain();
    idle(2);
    @(negedge clk);
    #1;
    checkOutput("hold_out_valid", 64'(out_valid), 64'd0);
    checkOutput("hold_b0", 64'(b0), 64'(lastB[0]));
    checkOutput("hold_b1", 64'(b1), 64'(lastB[1]));
    checkOutput("hold_b2", 64'(b2), 64'(lastB[2]));
    checkOutput("hold_b3", 64'(b3), 64'(lastB[3]));

    // Whole table back-to-back.
    foreach (table_v[i]) applyStimulus(table_v[i], 1'b1);
    idle(1);
    waitDrain();

    // Reset while a transform sits in stage 1: it must vanish.
    applyStimulus(mkVec(1, 2, 3, 4, 1, 3, 0, 2, 3, 4), 1'b0);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checkOutput("rst_mid_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_mid_b0", 64'(b0), 64'd0);
      checkOutput("rst_mid_b3", 64'(b3), 64'd0);
    end
    applyStimulus(table_v[1], 1'b1);
    idle(1);
    waitDrain();

    // Random transforms with roots 2 or 3, random gaps.
    for (int r = 0; r < 24; r++) begin
      for (int n = 0; n < 4; n++) rx[n] = $urandom_range(0, 4);
      rw = ($urandom_range(0, 1) == 1) ? 32'd2 : 32'd3;
      v.x  = rx;
      v.w0 = 32'd1;
      v.w1 = rw;
      v.b  = nttRef(rx, rw);
      applyStimulus(v, 1'b1);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(1);
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ntt_4pt.md
Name: ntt_4pt

Overview:
- 4-point number-theoretic transform over Z_Q with Q prime.
- Two-stage radix-2 decimation-in-time butterfly network; natural-order input, natural-order output.
- Twiddles (w0 = 1, w1 = primitive 4th root of unity mod Q) are supplied per transform.
- Leaf datapath block in the polynomial-multiplier NTT path, feeding pointwise multiplication and inverse NTT (inverse uses w1^-1; the caller scales by N^-1).

Parameters:
- WIDTH, 32, bit width of every coefficient and twiddle port.
- Q, 5, prime modulus; must satisfy 2 <= Q < 2^WIDTH, and Q-1 divisible by 4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  x0..x3, w0, w1 valid this cycle
- x0, x1, x2, x3  input  WIDTH  input coefficients, index order
- w0, w1  input  WIDTH  twiddles: w0 = omega^0, w1 = omega^1
- out_valid  output  1  b0..b3 valid
- b0, b1, b2, b3  output  WIDTH  transform coefficients, natural order

Behaviour:
- Reset: rst_n sampled low at a clk edge clears both pipeline stages. out_valid = 0; b0..b3 = 0; stage-1 valid = 0.
- Reset mid-operation discards in-flight data; no out_valid is produced for it.
- Arithmetic, all results in [0, Q-1]:
  - modmul(a,b) = (a*b) mod Q, computed on the full 2*WIDTH product.
  - modadd: s = a + b computed in WIDTH+1 bits; subtract Q if s >= Q.
  - modsub: a - b if a >= b, else a + Q - b.
- Butterfly bf(a, b, w): t = modmul(w, b); outputs (modadd(a, t), modsub(a, t)).
- Stage 1 registers on in_valid: (a0, a1) = bf(x0, x2, w0); (a2, a3) = bf(x1, x3, w0). w0 and w1 are registered alongside.
- Stage 2 registers on stage-1 valid: (b0, b2) = bf(a0, a2, w0'); (b1, b3) = bf(a1, a3, w1'), where w0', w1' are the registered twiddles.
- Net result: b_k = sum over n of x_n * w1^(n*k) mod Q, given w0 = 1 and w1^2 = Q-1.
- Latency: exactly 2 clk cycles from in_valid to out_valid.
- Throughput: one transform per cycle; back-to-back in_valid is fully supported, with no stalls and no backpressure.
- When in_valid = 0, stage data registers hold their value; valid bits shift 0. b0..b3 hold the last result while out_valid = 0.
- Input range: x and w must be in [0, Q-1]. Outputs for out-of-range inputs are unspecified unless NTT_INPUT_REDUCE_EN is defined.
- The twiddles are not checked; a non-root w1 yields the butterfly formula result with no error flag.

Optional Feature:
- Macro: NTT_INPUT_REDUCE_EN.
- Defined: x0..x3, w0, w1 are reduced mod Q combinationally before stage 1, so any WIDTH-bit value is legal. Latency stays 2.
- Undefined: no input reduction; inputs must already be < Q. Smaller area.

Decomposition:
- Package ntt_pkg:
  - WIDTH default and Q default.
  - Coefficient typedef coef_t = logic [WIDTH-1:0].
  - Functions mod_add, mod_sub, mod_mul.
- Sub-module ntt_butterfly: combinational, ports a, b, w -> hi, lo. Instantiated four times (two per stage).
- Pipeline registers and valid chain stay in ntt_4pt.

Test Plan:
- Q=5, x=[1,2,3,4], w0=1, w1=3, single in_valid pulse -> two cycles later out_valid=1, b=[0,2,3,4].
- Q=5, x=[2,3,3,0], w=(1,3) -> b=[3,3,2,0].
- Q=5, back-to-back in_valid on consecutive cycles with x=[0,2,3,4], w=(1,2) then x=[3,3,2,0], w=(1,2) -> b=[4,3,2,1], then next cycle b=[3,2,2,0]; out_valid high for 2 consecutive cycles.
- rst_n low for 1 cycle while a transform is in stage 1 -> out_valid stays 0, b=[0,0,0,0]; the next valid input completes normally after 2 cycles.
- Q=5, x=[4,4,4,4], w=(1,2) -> b=[1,0,0,0], exercising wrap-around in the adders; x=[0,0,0,0] -> b=[0,0,0,0].
- NTT_INPUT_REDUCE_EN defined, Q=5, x=[6,7,8,9], w=(6,8) -> same as x=[1,2,3,4], w=(1,3): b=[0,2,3,4].
